// File: rtl/demux_pkg.sv
// demux_pkg: shared select encodings and select type for the 1-to-4 demultiplexer.
//   SEL_A..SEL_D : select codes {a,b} for channels A..D
//   sel_t        : 2-bit select type
package demux_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_A = 2'b00;
    localparam sel_t SEL_B = 2'b01;
    localparam sel_t SEL_C = 2'b10;
    localparam sel_t SEL_D = 2'b11;

endpackage

// File: rtl/dec2to4.sv
// dec2to4: combinational 2-to-4 one-hot decoder.
//   sel    in  2  channel select ({a,b}, a is MSB)
//   onehot out 4  bit i set when channel i (0=A .. 3=D) is selected; all zero on unknown select
module dec2to4
    import demux_pkg::*;
(
    input  sel_t       sel,
    output logic [3:0] onehot
);

    always_comb begin
        onehot = 4'b0000;
        case (sel)
            SEL_A:   onehot = 4'b0001;
            SEL_B:   onehot = 4'b0010;
            SEL_C:   onehot = 4'b0100;
            SEL_D:   onehot = 4'b1000;
            // X/Z select in simulation drives every channel to zero
            default: onehot = 4'b0000;
        endcase
    end

endmodule

// File: rtl/demux.sv
// demux: thin wrapper around demux_1to4 with identical ports.
//   clk, rst_n, a, b, f in; A..D out (see demux_1to4)
module demux #(
    parameter int unsigned DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a,
    input  logic              b,
    input  logic [DATA_W-1:0] f,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] C,
    output logic [DATA_W-1:0] D
);

    demux_1to4 #(
        .DATA_W (DATA_W)
    ) u_demux_1to4 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .f     (f),
        .A     (A),
        .B     (B),
        .C     (C),
        .D     (D)
    );

endmodule

// File: rtl/demux_1to4.sv
// demux_1to4: 1-to-4 demultiplexer with registered outputs (1-cycle latency).
//   clk   in   1       rising-edge clock
//   rst_n in   1       synchronous active-low reset, clears A..D
//   a     in   1       select MSB
//   b     in   1       select LSB
//   f     in   DATA_W  data to route
//   A..D  out  DATA_W  channel outputs for {a,b} = 00/01/10/11; unselected channels load 0
module demux_1to4
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a,
    input  logic              b,
    input  logic [DATA_W-1:0] f,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] C,
    output logic [DATA_W-1:0] D
);

    sel_t              sel;
    logic [3:0]        onehot;
    logic [DATA_W-1:0] ch_d [4];
    logic [DATA_W-1:0] ch_q [4];

    assign sel = {a, b};

    dec2to4 u_dec2to4 (
        .sel    (sel),
        .onehot (onehot)
    );

    // Gating with the one-hot mask clears non-selected channels every cycle.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ch_d[i] = f & {DATA_W{onehot[i]}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                ch_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                ch_q[i] <= ch_d[i];
            end
        end
    end

    assign A = ch_q[0];
    assign B = ch_q[1];
    assign C = ch_q[2];
    assign D = ch_q[3];

endmodule

// File: tb/tb_demux_1to4.sv
// tb_demux_1to4: directed self-checking bench for demux_1to4 at DATA_W=1 and DATA_W=8.
module tb_demux_1to4;

    logic       clk;
    logic       rst_n;
    logic       a;
    logic       b;
    logic       f;
    logic [7:0] f_w;
    logic       a_n, b_n, c_n, d_n;
    logic [7:0] a_w, b_w, c_w, d_w;

    int checks;
    int failures;

    // Expected {D,C,B,A} for {a,b,f} = index
    logic [3:0] sweep_exp [8];

    demux_1to4 #(
        .DATA_W (1)
    ) demux (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .f     (f),
        .A     (a_n),
        .B     (b_n),
        .C     (c_n),
        .D     (d_n)
    );

    demux_1to4 #(
        .DATA_W (8)
    ) demux_w (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .f     (f_w),
        .A     (a_w),
        .B     (b_w),
        .C     (c_w),
        .D     (d_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // exp is {D,C,B,A} for the narrow instance
    task automatic check_narrow(input string tag, input logic [3:0] exp);
        check_val({tag, "_A"}, {7'd0, a_n}, {7'd0, exp[0]});
        check_val({tag, "_B"}, {7'd0, b_n}, {7'd0, exp[1]});
        check_val({tag, "_C"}, {7'd0, c_n}, {7'd0, exp[2]});
        check_val({tag, "_D"}, {7'd0, d_n}, {7'd0, exp[3]});
    endtask

    task automatic check_wide(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                              input logic [7:0] ec, input logic [7:0] ed);
        check_val({tag, "_A"}, a_w, ea);
        check_val({tag, "_B"}, b_w, eb);
        check_val({tag, "_C"}, c_w, ec);
        check_val({tag, "_D"}, d_w, ed);
    endtask

    // Advance one edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] v;
        logic       f_prev;
        int         ones;

        checks   = 0;
        failures = 0;
        sweep_exp[0] = 4'b0000;
        sweep_exp[1] = 4'b0001;
        sweep_exp[2] = 4'b0000;
        sweep_exp[3] = 4'b0010;
        sweep_exp[4] = 4'b0000;
        sweep_exp[5] = 4'b0100;
        sweep_exp[6] = 4'b0000;
        sweep_exp[7] = 4'b1000;

        // Reset held for two edges with data pending on D.
        rst_n = 1'b0;
        a     = 1'b1;
        b     = 1'b1;
        f     = 1'b1;
        f_w   = 8'hFF;
        step();
        check_narrow("rst0", 4'b0000);
        check_wide("rst0_w", 8'h00, 8'h00, 8'h00, 8'h00);
        step();
        check_narrow("rst1", 4'b0000);
        rst_n = 1'b1;
        step();
        check_narrow("rst_release", 4'b1000);
        check_wide("rst_release_w", 8'h00, 8'h00, 8'h00, 8'hFF);
        f_w = 8'h00;

        // Exhaustive sweep of {a,b,f}.
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {a, b, f} = v;
            step();
            check_narrow($sformatf("sweep%0d", i), sweep_exp[i]);
        end

        // Toggle pattern: f every cycle, b every 2, a every 4 (starting from all ones).
        for (int k = 0; k < 8; k++) begin
            v = 3'(7 - k);
            {a, b, f} = v;
            f_prev = f;
            step();
            check_narrow($sformatf("toggle%0d", k), sweep_exp[7 - k]);
            ones = int'(a_n) + int'(b_n) + int'(c_n) + int'(d_n);
            check_val($sformatf("toggle_onehot%0d", k), 8'(ones), {7'd0, f_prev});
            check_val($sformatf("toggle_or%0d", k), {7'd0, a_n | b_n | c_n | d_n},
                      {7'd0, f_prev});
        end

        // Wide data routing and clearing of the previous channel.
        a   = 1'b1;
        b   = 1'b0;
        f   = 1'b0;
        f_w = 8'hA5;
        step();
        check_wide("wide_c", 8'h00, 8'h00, 8'hA5, 8'h00);
        a   = 1'b0;
        b   = 1'b1;
        f_w = 8'h3C;
        step();
        check_wide("wide_b", 8'h00, 8'h3C, 8'h00, 8'h00);

        // Mid-stream reset.
        f_w = 8'h00;
        a   = 1'b0;
        b   = 1'b1;
        f   = 1'b1;
        step();
        check_narrow("mid_pre", 4'b0010);
        rst_n = 1'b0;
        step();
        check_narrow("mid_rst", 4'b0000);
        rst_n = 1'b1;
        a     = 1'b0;
        b     = 1'b0;
        f     = 1'b1;
        step();
        check_narrow("mid_resume", 4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
